// File: rtl/matmul_result_drain.sv
// matmul_result_drain: captures a finished NxN result matrix on the rising
// edge of done_in into a two-slot buffer and streams it out one element per
// valid/ready beat, row-major, tagging each beat with its row/column index.
module matmul_result_drain #(
  parameter int DATA_W = 16,
  parameter int N      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  done_in,
  input  logic [N*N*DATA_W-1:0] c_flat,
  input  logic                  clear_overrun,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [$clog2(N)-1:0]  out_row,
  output logic [$clog2(N)-1:0]  out_col,
  output logic                  out_last,
  output logic                  busy,
  output logic                  overrun,
  output logic [7:0]            frame_cnt
);

  localparam int RC_W  = $clog2(N);
  localparam int ELEMS = N * N;
  localparam int IDX_W = $clog2(ELEMS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS - 1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic [N*N*DATA_W-1:0] slot_data [2];
  logic [1:0]            slot_full;
  logic [1:0]            full_next;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  rd_ptr_next;
  logic [IDX_W-1:0]      idx;
  logic [0:0]            state;
  logic [0:0]            state_next;
  logic                  done_d;
  logic                  cap;
  logic                  beat;
  logic                  release_slot;
  logic                  slot_free;
  logic                  do_cap;
  logic                  drop;

  // Handshake, capture and slot-occupancy decisions for this edge
  always_comb begin
    cap          = done_in & ~done_d;
    beat         = (state == S_STREAM) & out_ready;
    release_slot = beat & (idx == LAST_IDX);
    // With both slots full the write pointer aliases the read slot, so a
    // slot released on this edge can take the new capture immediately.
    slot_free    = ~slot_full[wr_ptr] | (release_slot & (rd_ptr == wr_ptr));
    do_cap       = cap & slot_free;
    drop         = cap & ~slot_free;

    full_next = slot_full;
    if (release_slot) full_next[rd_ptr] = 1'b0;
    if (do_cap)       full_next[wr_ptr] = 1'b1;

    rd_ptr_next = release_slot ? ~rd_ptr : rd_ptr;
    state_next  = full_next[rd_ptr_next] ? S_STREAM : S_IDLE;
  end

  // Control state: edge detector, slot flags, pointers, element index, counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_d    <= 1'b0;
      slot_full <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      idx       <= '0;
      state     <= S_IDLE;
      frame_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      done_d    <= done_in;
      slot_full <= full_next;
      rd_ptr    <= rd_ptr_next;
      state     <= state_next;
      if (do_cap) wr_ptr <= ~wr_ptr;
      if (release_slot) begin
        idx       <= '0;
        frame_cnt <= frame_cnt + 8'd1;
      end else if (beat) begin
        idx <= idx + 1'b1;
      end
      if (drop)               overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;
    end
  end

  // Result storage; contents are only observed while the slot is marked full
  always_ff @(posedge clk) begin
    if (do_cap) slot_data[wr_ptr] <= c_flat;
  end

  // Output beat decode; fields read as zero while no beat is offered
  always_comb begin
    out_valid = (state == S_STREAM);
    busy      = slot_full[0] | slot_full[1];
    out_data  = '0;
    out_row   = '0;
    out_col   = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_data = slot_data[rd_ptr][32'(idx) * DATA_W +: DATA_W];
      out_row  = RC_W'(32'(idx) / N);
      out_col  = RC_W'(32'(idx) % N);
      out_last = (idx == LAST_IDX);
    end
  end

endmodule

// File: tb/tb_matmul_result_drain.sv
// Bench for matmul_result_drain: a hand-computed vector table for the first
// frame, directed multi-cycle corner sequences, and a randomized run, all
// checked against a frame-queue reference model.
module tb_matmul_result_drain;

  localparam int DW = 16;
  localparam int NN = 4;
  localparam int FW = NN * NN * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          done_in;
  logic [FW-1:0] c_flat;
  logic          clear_overrun;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_row;
  logic [1:0]    out_col;
  logic          out_last;
  logic          busy;
  logic          overrun;
  logic [7:0]    frame_cnt;

  int checks = 0;
  int errors = 0;

  matmul_result_drain #(.DATA_W(DW), .N(NN)) dut (
    .clk(clk), .rst_n(rst_n), .done_in(done_in), .c_flat(c_flat),
    .clear_overrun(clear_overrun), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .busy(busy), .overrun(overrun), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: queue of buffered frames ----------------
  logic [FW-1:0] mq [$];
  int            m_idx;
  int            m_fc;
  bit            m_ovr;
  bit            m_done_d;

  function automatic void model_reset();
    mq.delete();
    m_idx = 0; m_fc = 0; m_ovr = 0; m_done_d = 0;
  endfunction

  // One clock edge: consumer takes a beat first, then a new frame may enter.
  function automatic void model_edge();
    bit drop = 0;
    if (mq.size() > 0 && out_ready) begin
      if (m_idx == NN * NN - 1) begin
        void'(mq.pop_front());
        m_idx = 0;
        m_fc  = (m_fc + 1) % 256;
      end else begin
        m_idx++;
      end
    end
    if (done_in && !m_done_d) begin
      if (mq.size() < 2) mq.push_back(c_flat);
      else               drop = 1;
    end
    if (drop)               m_ovr = 1;
    else if (clear_overrun) m_ovr = 0;
    m_done_d = done_in;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_compare();
    logic [FW-1:0] f;
    chk("valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("busy", 32'(busy), 32'(mq.size() > 0));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_fc));
    if (mq.size() > 0) begin
      f = mq[0];
      chk("data", 32'(out_data), 32'(f[m_idx * DW +: DW]));
      chk("row", 32'(out_row), 32'(m_idx / NN));
      chk("col", 32'(out_col), 32'(m_idx % NN));
      chk("last", 32'(out_last), 32'(m_idx == NN * NN - 1));
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    model_compare();
  endtask

  function automatic logic [FW-1:0] frame_pattern(int base);
    logic [FW-1:0] f = '0;
    for (int unsigned k = 0; k < NN * NN; k++) f[k * DW +: DW] = DW'(base + int'(k));
    return f;
  endfunction

  function automatic logic [FW-1:0] frame_random();
    logic [FW-1:0] f;
    for (int unsigned k = 0; k < NN * NN; k++) f[k * DW +: DW] = DW'($urandom);
    return f;
  endfunction

  // ---------------- vector table for the first frame ----------------
  typedef struct {
    bit          done;
    bit          rdy;
    bit          v;
    logic [15:0] d;
    int          r;
    int          c;
    bit          last;
    bit          b;
    int          fc;
  } vec_t;

  vec_t vt [21];

  initial begin
    logic [FW-1:0] ident;
    int            valid_run;

    ident = '0;
    for (int unsigned i = 0; i < NN; i++) ident[(i * NN + i) * DW +: DW] = 16'd2;

    //           done rdy v  data r  c  last busy fc
    vt[0]  = '{1, 1, 1, 16'd2, 0, 0, 0, 1, 0};
    vt[1]  = '{1, 0, 1, 16'd2, 0, 0, 0, 1, 0};
    vt[2]  = '{1, 1, 1, 16'd0, 0, 1, 0, 1, 0};
    vt[3]  = '{0, 1, 1, 16'd0, 0, 2, 0, 1, 0};
    vt[4]  = '{0, 1, 1, 16'd0, 0, 3, 0, 1, 0};
    vt[5]  = '{0, 1, 1, 16'd0, 1, 0, 0, 1, 0};
    vt[6]  = '{0, 1, 1, 16'd2, 1, 1, 0, 1, 0};
    vt[7]  = '{0, 0, 1, 16'd2, 1, 1, 0, 1, 0};
    vt[8]  = '{0, 1, 1, 16'd0, 1, 2, 0, 1, 0};
    vt[9]  = '{0, 1, 1, 16'd0, 1, 3, 0, 1, 0};
    vt[10] = '{0, 1, 1, 16'd0, 2, 0, 0, 1, 0};
    vt[11] = '{0, 1, 1, 16'd0, 2, 1, 0, 1, 0};
    vt[12] = '{0, 1, 1, 16'd2, 2, 2, 0, 1, 0};
    vt[13] = '{0, 0, 1, 16'd2, 2, 2, 0, 1, 0};
    vt[14] = '{0, 1, 1, 16'd0, 2, 3, 0, 1, 0};
    vt[15] = '{0, 1, 1, 16'd0, 3, 0, 0, 1, 0};
    vt[16] = '{0, 1, 1, 16'd0, 3, 1, 0, 1, 0};
    vt[17] = '{0, 1, 1, 16'd0, 3, 2, 0, 1, 0};
    vt[18] = '{0, 1, 1, 16'd2, 3, 3, 1, 1, 0};
    vt[19] = '{0, 1, 0, 16'd0, 0, 0, 0, 0, 1};
    vt[20] = '{0, 1, 0, 16'd0, 0, 0, 0, 0, 1};

    // Reset held with done high and ready high: everything idle and zero.
    rst_n = 1'b0; done_in = 1'b1; out_ready = 1'b1; clear_overrun = 1'b0;
    c_flat = ident;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_rowcol", 32'({out_row, out_col, out_last}), 0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      done_in   = vt[i].done;
      out_ready = vt[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].v));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].b));
      chk($sformatf("vec%0d_fc", i), 32'(frame_cnt), 32'(vt[i].fc));
      chk($sformatf("vec%0d_ovr", i), 32'(overrun), 0);
      if (vt[i].v) begin
        chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vt[i].d));
        chk($sformatf("vec%0d_row", i), 32'(out_row), 32'(vt[i].r));
        chk($sformatf("vec%0d_col", i), 32'(out_col), 32'(vt[i].c));
        chk($sformatf("vec%0d_last", i), 32'(out_last), 32'(vt[i].last));
      end
    end

    // Re-synchronise DUT and model from reset for the model-checked phases.
    rst_n = 1'b0; done_in = 1'b0; out_ready = 1'b0;
    model_reset();
    @(posedge clk); #2 rst_n = 1'b1;

    // Double buffer: A then B captured under backpressure, drained gap-free.
    c_flat = frame_pattern(0);     done_in = 1'b1; tick();
    done_in = 1'b0;                tick();
    c_flat = frame_pattern(16'h100); done_in = 1'b1; tick();
    done_in = 1'b0;                tick(); tick();
    out_ready = 1'b1;
    valid_run = 0;
    for (int k = 0; k < 32; k++) begin
      if (out_valid) valid_run++;
      tick();
    end
    chk("dbuf_no_gap", 32'(valid_run), 32);
    chk("dbuf_frames", 32'(frame_cnt), 2);
    chk("dbuf_overrun", 32'(overrun), 0);

    // Overrun: three edges with nothing drained; third is dropped.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      c_flat = frame_random(); done_in = 1'b1; tick();
      done_in = 1'b0; tick();
    end
    chk("ovr_set", 32'(overrun), 1);
    // Clear on the same edge as another dropped capture: set wins.
    done_in = 1'b1; clear_overrun = 1'b1; tick();
    done_in = 1'b0; clear_overrun = 1'b0; tick();
    chk("ovr_set_wins", 32'(overrun), 1);
    clear_overrun = 1'b1; tick();
    clear_overrun = 1'b0;
    chk("ovr_cleared", 32'(overrun), 0);
    // Drain 15 beats, then capture on the last-beat edge with both slots full.
    out_ready = 1'b1;
    repeat (15) tick();
    c_flat = frame_random(); done_in = 1'b1; tick();
    done_in = 1'b0;
    chk("ovr_free_on_last", 32'(overrun), 0);
    repeat (33) tick();
    chk("ovr_drained_busy", 32'(busy), 0);

    // Backpressure with pseudo-random ready over a frame.
    c_flat = frame_random(); done_in = 1'b1; tick(); done_in = 1'b0;
    for (int k = 0; k < 60; k++) begin
      out_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    out_ready = 1'b1; repeat (17) tick();

    // Reset mid-stream after 7 beats: stream aborts at once.
    c_flat = frame_random(); done_in = 1'b1; tick(); done_in = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0; model_reset();
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_fc", 32'(frame_cnt), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    c_flat = frame_random(); done_in = 1'b1; tick(); done_in = 1'b0;
    chk("midrst_restart_row", 32'({out_valid, out_row, out_col}), 32'h10);
    repeat (18) tick();

    // Randomized run against the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) done_in = ~done_in;
      out_ready     = (k % 1000 < 300) ? ($urandom_range(0, 7) == 0)
                                       : ($urandom_range(0, 3) != 0);
      clear_overrun = ($urandom_range(0, 40) == 0);
      c_flat        = frame_random();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
